// File: rtl/alu_flag_pkg.sv
// Shared types and constants for the ALU status-flag unit: operation and
// condition-code encodings, flag bit positions, and the condition evaluator.
package alu_flag_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_INC = 3'b010,
        OP_DEC = 3'b011
    } opsel_e;

    typedef enum logic [3:0] {
        CC_EQ = 4'd0,
        CC_NE = 4'd1,
        CC_CS = 4'd2,
        CC_CC = 4'd3,
        CC_MI = 4'd4,
        CC_PL = 4'd5,
        CC_VS = 4'd6,
        CC_VC = 4'd7,
        CC_HI = 4'd8,
        CC_LS = 4'd9,
        CC_GE = 4'd10,
        CC_LT = 4'd11,
        CC_GT = 4'd12,
        CC_LE = 4'd13,
        CC_AL = 4'd14,
        CC_NV = 4'd15
    } cond_e;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_S = 2;
    localparam int FLAG_O = 3;

    // Evaluates a condition code against a {O,S,Z,C} flag vector.
    function automatic logic eval_cond(input logic [3:0] cc, input logic [3:0] f);
        logic c;
        logic z;
        logic s;
        logic o;
        logic res;
        c = f[FLAG_C];
        z = f[FLAG_Z];
        s = f[FLAG_S];
        o = f[FLAG_O];
        case (cond_e'(cc))
            CC_EQ:   res = z;
            CC_NE:   res = !z;
            CC_CS:   res = c;
            CC_CC:   res = !c;
            CC_MI:   res = s;
            CC_PL:   res = !s;
            CC_VS:   res = o;
            CC_VC:   res = !o;
            CC_HI:   res = c && !z;
            CC_LS:   res = !c || z;
            CC_GE:   res = (s == o);
            CC_LT:   res = (s != o);
            CC_GT:   res = !z && (s == o);
            CC_LE:   res = z || (s != o);
            CC_AL:   res = 1'b1;
            CC_NV:   res = 1'b0;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_flag_calc.sv
// Combinational next-flag computation from the ALU result and operand signs.
// INC/DEC behave as ADD/SUB with an implicit non-negative second operand.
module alu_flag_calc
    import alu_flag_pkg::*;
#(
    parameter int WIDTH = 128
) (
    input  logic [2:0]       opsel,
    input  logic             a_msb,
    input  logic             b_msb,
    input  logic             cout,
    input  logic [WIDTH-1:0] result,
    output logic [3:0]       flags_nxt
);

    logic res_zero;
    logic res_sign;

    assign res_zero = (result == '0);
    assign res_sign = result[WIDTH-1];

    always_comb begin
        flags_nxt         = '0;
        flags_nxt[FLAG_Z] = res_zero;
        flags_nxt[FLAG_S] = res_sign;
        case (opsel)
            OP_ADD: begin
                flags_nxt[FLAG_C] = cout;
                flags_nxt[FLAG_O] = (a_msb == b_msb) && (res_sign != a_msb);
            end
            OP_SUB: begin
                flags_nxt[FLAG_C] = cout;
                flags_nxt[FLAG_O] = (a_msb != b_msb) && (res_sign != a_msb);
            end
            OP_INC: begin
                flags_nxt[FLAG_C] = cout;
                flags_nxt[FLAG_O] = (a_msb == 1'b0) && (res_sign != a_msb);
            end
            OP_DEC: begin
                flags_nxt[FLAG_C] = cout;
                flags_nxt[FLAG_O] = (a_msb != 1'b0) && (res_sign != a_msb);
            end
            // Logic/shift operations never produce carry or overflow.
            default: begin
                flags_nxt[FLAG_C] = 1'b0;
                flags_nxt[FLAG_O] = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_flag_unit.sv
// Registered ALU status flags with sticky accumulation, a saturating
// overflow-event counter and a combinational condition-code evaluator.
module alu_flag_unit
    import alu_flag_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [2:0]       opsel,
    input  logic             a_msb,
    input  logic             b_msb,
    input  logic             cout,
    input  logic [WIDTH-1:0] result,
    output logic [3:0]       flags_q,
    output logic             flags_valid,
    output logic [3:0]       sticky_q,
    input  logic [3:0]       sticky_clr,
    input  logic [3:0]       cond,
    output logic             cond_true,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             ovf_count_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [3:0]       flags_nxt;
    logic [3:0]       flags_d;
    logic [3:0]       sticky_d;
    logic [CNT_W-1:0] ovf_cnt_q;
    logic [CNT_W-1:0] ovf_cnt_d;
    logic [CNT_W-1:0] ovf_cnt_base;

    alu_flag_calc #(
        .WIDTH (WIDTH)
    ) u_calc (
        .opsel     (opsel),
        .a_msb     (a_msb),
        .b_msb     (b_msb),
        .cout      (cout),
        .result    (result),
        .flags_nxt (flags_nxt)
    );

    // Clear applies first so a same-cycle set from a valid update survives.
    always_comb begin
        flags_d  = in_valid ? flags_nxt : flags_q;
        sticky_d = sticky_q & ~sticky_clr;
        if (in_valid) begin
            sticky_d = sticky_d | flags_nxt;
        end
    end

    always_comb begin
        ovf_cnt_base = ovf_count_clr ? '0 : ovf_cnt_q;
        ovf_cnt_d    = ovf_cnt_base;
        if (in_valid && flags_nxt[FLAG_O] && (ovf_cnt_base != CNT_MAX)) begin
            ovf_cnt_d = ovf_cnt_base + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q     <= '0;
            flags_valid <= 1'b0;
            sticky_q    <= '0;
            ovf_cnt_q   <= '0;
        end else begin
            flags_q     <= flags_d;
            flags_valid <= in_valid;
            sticky_q    <= sticky_d;
            ovf_cnt_q   <= ovf_cnt_d;
        end
    end

    assign ovf_count = ovf_cnt_q;
    assign cond_true = eval_cond(cond, flags_q);

endmodule

// File: tb/tb_alu_flag_unit.sv
// Directed bench for alu_flag_unit (WIDTH=128, CNT_W=2) with hand-computed
// expected flags, sticky bits, counter values and condition results.
`timescale 1ns/1ps
module tb_alu_flag_unit;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [2:0]   opsel;
    logic         a_msb;
    logic         b_msb;
    logic         cout;
    logic [127:0] result;
    logic [3:0]   flags_q;
    logic         flags_valid;
    logic [3:0]   sticky_q;
    logic [3:0]   sticky_clr;
    logic [3:0]   cond;
    logic         cond_true;
    logic [1:0]   ovf_count;
    logic         ovf_count_clr;

    int checks;
    int failures;

    logic [127:0] msb_only;
    logic [127:0] one_val;

    alu_flag_unit #(
        .WIDTH (128),
        .CNT_W (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .opsel         (opsel),
        .a_msb         (a_msb),
        .b_msb         (b_msb),
        .cout          (cout),
        .result        (result),
        .flags_q       (flags_q),
        .flags_valid   (flags_valid),
        .sticky_q      (sticky_q),
        .sticky_clr    (sticky_clr),
        .cond          (cond),
        .cond_true     (cond_true),
        .ovf_count     (ovf_count),
        .ovf_count_clr (ovf_count_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic a, input logic b,
                         input logic co, input logic [127:0] r);
        in_valid = v;
        opsel    = op;
        a_msb    = a;
        b_msb    = b;
        cout     = co;
        result   = r;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, '0);
        sticky_clr = 4'b0000;
        ovf_count_clr = 1'b0;
        cond = 4'd0;
        step();
        step();
        checks++; if (flags_q !== 4'b0000) begin failures++; $display("FAIL reset_flags: got %b expected %b", flags_q, 4'b0000); end
        checks++; if (flags_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected %b", flags_valid, 1'b0); end
        checks++; if (sticky_q !== 4'b0000) begin failures++; $display("FAIL reset_sticky: got %b expected %b", sticky_q, 4'b0000); end
        checks++; if (ovf_count !== 2'd0) begin failures++; $display("FAIL reset_count: got %0d expected %0d", ovf_count, 0); end
        checks++; if (cond_true !== 1'b0) begin failures++; $display("FAIL reset_cond_eq: got %b expected %b", cond_true, 1'b0); end
        cond = 4'd14;
        #1;
        checks++; if (cond_true !== 1'b1) begin failures++; $display("FAIL reset_cond_al: got %b expected %b", cond_true, 1'b1); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add_overflow();
        drive(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, msb_only);
        step();
        drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, '0);
        checks++; if (flags_q !== 4'b1100) begin failures++; $display("FAIL add_ovf_flags: got %b expected %b", flags_q, 4'b1100); end
        checks++; if (flags_valid !== 1'b1) begin failures++; $display("FAIL add_ovf_valid: got %b expected %b", flags_valid, 1'b1); end
        checks++; if (ovf_count !== 2'd1) begin failures++; $display("FAIL add_ovf_count: got %0d expected %0d", ovf_count, 1); end
        checks++; if (sticky_q !== 4'b1100) begin failures++; $display("FAIL add_ovf_sticky: got %b expected %b", sticky_q, 4'b1100); end
        // Positive overflow: S and O both set, so signed "less than" is false.
        cond = 4'd11;
        #1;
        checks++; if (cond_true !== 1'b0) begin failures++; $display("FAIL add_ovf_lt: got %b expected %b", cond_true, 1'b0); end
        cond = 4'd10;
        #1;
        checks++; if (cond_true !== 1'b1) begin failures++; $display("FAIL add_ovf_ge: got %b expected %b", cond_true, 1'b1); end
        step();
        checks++; if (flags_valid !== 1'b0) begin failures++; $display("FAIL add_ovf_pulse: got %b expected %b", flags_valid, 1'b0); end
    endtask

    task automatic test_sub_equal();
        logic [15:0] exp_cc;
        exp_cc = 16'h66A5;
        drive(1'b1, 3'b001, 1'b1, 1'b1, 1'b1, '0);
        step();
        drive(1'b0, 3'b001, 1'b1, 1'b1, 1'b1, '0);
        checks++; if (flags_q !== 4'b0011) begin failures++; $display("FAIL sub_eq_flags: got %b expected %b", flags_q, 4'b0011); end
        checks++; if (sticky_q !== 4'b1111) begin failures++; $display("FAIL sub_eq_sticky: got %b expected %b", sticky_q, 4'b1111); end
        checks++; if (ovf_count !== 2'd1) begin failures++; $display("FAIL sub_eq_count: got %0d expected %0d", ovf_count, 1); end
        for (int i = 0; i < 16; i++) begin
            cond = 4'(i);
            #0.5;
            checks++;
            if (cond_true !== exp_cc[i]) begin
                failures++;
                $display("FAIL sub_eq_cond%0d: got %b expected %b", i, cond_true, exp_cc[i]);
            end
        end
        step();
    endtask

    task automatic test_logic_sticky();
        drive(1'b1, 3'b100, 1'b0, 1'b1, 1'b1, '1);
        step();
        drive(1'b0, 3'b100, 1'b0, 1'b1, 1'b1, '1);
        checks++; if (flags_q !== 4'b0100) begin failures++; $display("FAIL logic_flags: got %b expected %b", flags_q, 4'b0100); end
        checks++; if (sticky_q !== 4'b1111) begin failures++; $display("FAIL logic_sticky: got %b expected %b", sticky_q, 4'b1111); end
        sticky_clr = 4'b0011;
        step();
        sticky_clr = 4'b0000;
        checks++; if (sticky_q !== 4'b1100) begin failures++; $display("FAIL sticky_clr_zc: got %b expected %b", sticky_q, 4'b1100); end
        checks++; if (flags_q !== 4'b0100) begin failures++; $display("FAIL sticky_clr_flags: got %b expected %b", flags_q, 4'b0100); end
        // Negative overflow alongside a clear of sticky O: the set wins.
        drive(1'b1, 3'b000, 1'b1, 1'b1, 1'b1, one_val);
        sticky_clr = 4'b1000;
        step();
        drive(1'b0, 3'b000, 1'b1, 1'b1, 1'b1, one_val);
        sticky_clr = 4'b0000;
        checks++; if (flags_q !== 4'b1001) begin failures++; $display("FAIL neg_ovf_flags: got %b expected %b", flags_q, 4'b1001); end
        checks++; if (sticky_q !== 4'b1101) begin failures++; $display("FAIL sticky_set_wins: got %b expected %b", sticky_q, 4'b1101); end
        checks++; if (ovf_count !== 2'd2) begin failures++; $display("FAIL neg_ovf_count: got %0d expected %0d", ovf_count, 2); end
    endtask

    task automatic test_hold();
        logic [15:0] exp_cc;
        exp_cc = 16'h6966;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 3'(i), 1'b0, 1'b0, 1'b0, (i == 1) ? '0 : msb_only);
            step();
            checks++; if (flags_q !== 4'b1001) begin failures++; $display("FAIL hold_flags%0d: got %b expected %b", i, flags_q, 4'b1001); end
            checks++; if (flags_valid !== 1'b0) begin failures++; $display("FAIL hold_valid%0d: got %b expected %b", i, flags_valid, 1'b0); end
            checks++; if (ovf_count !== 2'd2) begin failures++; $display("FAIL hold_count%0d: got %0d expected %0d", i, ovf_count, 2); end
        end
        for (int i = 0; i < 16; i++) begin
            cond = 4'(i);
            #0.5;
            checks++;
            if (cond_true !== exp_cc[i]) begin
                failures++;
                $display("FAIL hold_cond%0d: got %b expected %b", i, cond_true, exp_cc[i]);
            end
        end
        step();
    endtask

    task automatic test_no_overflow();
        // Same-sign SUB and mixed-sign ADD cannot overflow.
        drive(1'b1, 3'b001, 1'b0, 1'b0, 1'b0, msb_only);
        step();
        checks++; if (flags_q !== 4'b0100) begin failures++; $display("FAIL sub_noovf_flags: got %b expected %b", flags_q, 4'b0100); end
        drive(1'b1, 3'b000, 1'b0, 1'b1, 1'b0, msb_only);
        step();
        drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, '0);
        checks++; if (flags_q !== 4'b0100) begin failures++; $display("FAIL add_noovf_flags: got %b expected %b", flags_q, 4'b0100); end
        checks++; if (ovf_count !== 2'd2) begin failures++; $display("FAIL noovf_count: got %0d expected %0d", ovf_count, 2); end
    endtask

    task automatic test_back_to_back_saturation();
        logic [1:0] exp_cnt [5];
        logic [3:0] exp_flg [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        exp_flg = '{4'b1100, 4'b1100, 4'b1001, 4'b1100, 4'b1100};
        ovf_count_clr = 1'b1;
        step();
        ovf_count_clr = 1'b0;
        checks++; if (ovf_count !== 2'd0) begin failures++; $display("FAIL count_clr: got %0d expected %0d", ovf_count, 0); end
        for (int i = 0; i < 5; i++) begin
            case (i)
                1:       drive(1'b1, 3'b010, 1'b0, 1'b1, 1'b0, msb_only);
                2:       drive(1'b1, 3'b011, 1'b1, 1'b1, 1'b1, one_val);
                3:       drive(1'b1, 3'b001, 1'b0, 1'b1, 1'b0, msb_only);
                default: drive(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, msb_only);
            endcase
            step();
            checks++; if (ovf_count !== exp_cnt[i]) begin failures++; $display("FAIL sat_count%0d: got %0d expected %0d", i, ovf_count, exp_cnt[i]); end
            checks++; if (flags_q !== exp_flg[i]) begin failures++; $display("FAIL sat_flags%0d: got %b expected %b", i, flags_q, exp_flg[i]); end
            checks++; if (flags_valid !== 1'b1) begin failures++; $display("FAIL sat_valid%0d: got %b expected %b", i, flags_valid, 1'b1); end
        end
        drive(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, msb_only);
        ovf_count_clr = 1'b1;
        step();
        ovf_count_clr = 1'b0;
        drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, '0);
        checks++; if (ovf_count !== 2'd1) begin failures++; $display("FAIL clr_with_ovf: got %0d expected %0d", ovf_count, 1); end
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, msb_only);
        sticky_clr = 4'b0000;
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (flags_q !== 4'b0000) begin failures++; $display("FAIL midrst_flags: got %b expected %b", flags_q, 4'b0000); end
        checks++; if (sticky_q !== 4'b0000) begin failures++; $display("FAIL midrst_sticky: got %b expected %b", sticky_q, 4'b0000); end
        checks++; if (ovf_count !== 2'd0) begin failures++; $display("FAIL midrst_count: got %0d expected %0d", ovf_count, 0); end
        step();
        checks++; if (flags_q !== 4'b0000) begin failures++; $display("FAIL midrst_discard: got %b expected %b", flags_q, 4'b0000); end
        checks++; if (flags_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b expected %b", flags_valid, 1'b0); end
        cond = 4'd14;
        #1;
        checks++; if (cond_true !== 1'b1) begin failures++; $display("FAIL midrst_cond_al: got %b expected %b", cond_true, 1'b1); end
        cond = 4'd0;
        #1;
        checks++; if (cond_true !== 1'b0) begin failures++; $display("FAIL midrst_cond_eq: got %b expected %b", cond_true, 1'b0); end
        drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, '0);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        msb_only = '0;
        msb_only[127] = 1'b1;
        one_val  = 128'd1;
        test_reset();
        test_add_overflow();
        test_sub_equal();
        test_logic_sticky();
        test_hold();
        test_no_overflow();
        test_back_to_back_saturation();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
